fpu_seq: RTL and testbench

- Sequencer between the RISC5 execute stage and the three floating-point units (adder, multiplier, divider).
- Accepts one FP request at a time and registers the operands.
- Drives the selected unit's run line until that unit drops stall, then captures the unit's result into a result register.
- Returns the result to the CPU with a one-cycle valid pulse.

---
 rtl/fpu_seq.sv | 149 ++++++++++++++
 tb/tb_fpu_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// Sequencer between the RISC5 execute stage and the FP adder/multiplier/divider.
// Optional watchdog on the RUN state is enabled with `define FPU_TMO_EN.
module fpu_seq #(
  parameter int TMO_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        res_valid,
  output logic [31:0] res_z,
  output logic        res_err,
  output logic [31:0] fu_x,
  output logic [31:0] fu_y,
  output logic [1:0]  add_op,
  output logic        add_run,
  input  logic        add_stall,
  input  logic [31:0] add_z,
  output logic        mul_run,
  input  logic        mul_stall,
  input  logic [31:0] mul_z,
  output logic        div_run,
  input  logic        div_stall,
  input  logic [31:0] div_z
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_r;
  logic        accept;
  logic        illegal;
  logic        capture;
  logic        timeout;
  logic        sel_stall;
  logic [31:0] sel_z;

  assign illegal = (req_op[2:1] == 2'b11);
  assign add_op  = op_r[1:0];

`ifdef FPU_TMO_EN
  logic [TMO_BITS-1:0] tmo_cnt;
  logic [TMO_BITS-1:0] tmo_inc;
  logic                tmo_hit;

  // tmo_cnt holds the number of completed RUN cycles; the limit fires in RUN cycle 2^TMO_BITS-1
  assign tmo_inc = tmo_cnt + TMO_BITS'(1);
  assign tmo_hit = &tmo_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (accept)
      tmo_cnt <= '0;
    else if (state == RUN)
      tmo_cnt <= tmo_inc;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    add_run   = 1'b0;
    mul_run   = 1'b0;
    div_run   = 1'b0;
    sel_stall = add_stall;
    sel_z     = add_z;
    if (op_r == 3'b100) begin
      sel_stall = mul_stall;
      sel_z     = mul_z;
    end else if (op_r == 3'b101) begin
      sel_stall = div_stall;
      sel_z     = div_z;
    end
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = illegal ? DONE : RUN;
        end
      end
      RUN: begin
        // run lines decode from the state register so reset drops them asynchronously
        add_run = !op_r[2];
        mul_run = (op_r == 3'b100);
        div_run = (op_r == 3'b101);
        if (!sel_stall) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
`ifdef FPU_TMO_EN
        else if (tmo_hit) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fu_x    <= '0;
      fu_y    <= '0;
      op_r    <= '0;
      res_z   <= '0;
      res_err <= 1'b0;
    end else begin
      if (accept) begin
        fu_x <= req_x;
        fu_y <= req_y;
        op_r <= req_op;
        if (illegal) begin
          res_z   <= '0;
          res_err <= 1'b1;
        end
      end
      if (capture) begin
        res_z   <= sel_z;
        res_err <= 1'b0;
      end
      if (timeout) begin
        res_z   <= '0;
        res_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq: behavioural FP unit stubs plus a latency/result model.
// Build with FPU_TMO_EN defined to exercise the watchdog scenario.
module tb_fpu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        req_ready, res_valid, res_err;
  logic [31:0] res_z, fu_x, fu_y;
  logic [1:0]  add_op;
  logic        add_run, mul_run, div_run;
  logic        add_stall, mul_stall, div_stall;
  logic [31:0] add_z = '0;
  logic [31:0] mul_z = '0;
  logic [31:0] div_z = '0;

  int checks = 0;
  int errors = 0;

  // unit stubs: each holds stall for lat-1 run cycles, so it runs for lat cycles
  int add_lat = 4, mul_lat = 26, div_lat = 27;
  int add_cnt = 0, mul_cnt = 0, div_cnt = 0;
  bit mul_force = 1'b0;

  // observations filled by run_op
  int          w, dc, na, nm, nd;
  logic [31:0] z, pz;
  logic        e, pv, pr;
  bit          st;

  fpu_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .res_valid(res_valid), .res_z(res_z), .res_err(res_err),
    .fu_x(fu_x), .fu_y(fu_y), .add_op(add_op),
    .add_run(add_run), .add_stall(add_stall), .add_z(add_z),
    .mul_run(mul_run), .mul_stall(mul_stall), .mul_z(mul_z),
    .div_run(div_run), .div_stall(div_stall), .div_z(div_z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    add_cnt <= add_run ? add_cnt + 1 : 0;
    mul_cnt <= mul_run ? mul_cnt + 1 : 0;
    div_cnt <= div_run ? div_cnt + 1 : 0;
  end

  assign add_stall = add_run && (add_cnt < add_lat - 1);
  assign mul_stall = mul_run && (mul_force || (mul_cnt < mul_lat - 1));
  assign div_stall = div_run && (div_cnt < div_lat - 1);

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "[TB] time limit");
  end

  // reference model: DONE cycle index counted from the accept edge
  function automatic int model_cycles(input logic [2:0] op);
    if (op[2:1] == 2'b11) return 1;
    if (!op[2]) return add_lat + 1;
    if (op[0]) return div_lat + 1;
    return mul_lat + 1;
  endfunction

  function automatic logic [31:0] model_z(input logic [2:0] op);
    if (op[2:1] == 2'b11) return 32'h0;
    if (!op[2]) return add_z;
    if (op[0]) return div_z;
    return mul_z;
  endfunction

  // drive one request and observe until res_valid; assumes it starts just after a negedge
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit hold, input logic [2:0] nop, input logic [31:0] nx);
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'($urandom); req_x = $urandom; req_y = $urandom;
    dc = -1; na = 0; nm = 0; nd = 0; st = 1'b1; z = 'x; e = 1'bx;
    for (int k = 1; k <= 200; k++) begin
      na += int'(add_run); nm += int'(mul_run); nd += int'(div_run);
      if (fu_x !== x || fu_y !== y || add_op !== op[1:0]) st = 1'b0;
      if (res_valid === 1'b1) begin
        dc = k; z = res_z; e = res_err;
        break;
      end
      @(negedge clk);
    end
    if (hold) begin
      req_valid = 1'b1; req_op = nop; req_x = nx; req_y = $urandom;
    end
    @(negedge clk);
    pv = res_valid; pr = req_ready; pz = res_z;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({res_valid, req_ready, add_run, mul_run, div_run} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {res_valid, req_ready, add_run, mul_run, div_run});
    end
    checks++;
    if ({res_z, res_err, fu_x, fu_y, add_op} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got z=%h err=%b x=%h y=%h op=%b expected all zero", res_z, res_err, fu_x, fu_y, add_op);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", req_ready, res_valid);
    end
  endtask

  task automatic test_fad();
    add_z = 32'h40400000;
    run_op(3'b000, 32'h3F800000, 32'h40000000, 1'b0, 3'b0, 32'h0);
    checks++;
    if (dc !== 5) begin errors++; $display("[TB] FAIL fad_latency: got %0d expected 5", dc); end
    checks++;
    if (z !== 32'h40400000 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL fad_result: got z=%h err=%b expected z=40400000 err=0", z, e);
    end
    checks++;
    if (na !== 4 || nm !== 0 || nd !== 0) begin
      errors++; $display("[TB] FAIL fad_runs: got add=%0d mul=%0d div=%0d expected 4/0/0", na, nm, nd);
    end
    checks++;
    if (st !== 1'b1 || pv !== 1'b0 || pz !== 32'h40400000) begin
      errors++; $display("[TB] FAIL fad_stable_pulse: got stable=%b next_valid=%b held_z=%h expected 1/0/40400000", st, pv, pz);
    end
  endtask

  task automatic test_fml();
    mul_z = 32'h40400000;
    run_op(3'b100, 32'h3FC00000, 32'h40000000, 1'b0, 3'b0, 32'h0);
    checks++;
    if (dc !== 27) begin errors++; $display("[TB] FAIL fml_latency: got %0d expected 27", dc); end
    checks++;
    if (z !== 32'h40400000 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL fml_result: got z=%h err=%b expected z=40400000 err=0", z, e);
    end
    checks++;
    if (na !== 0 || nm !== 26 || nd !== 0 || st !== 1'b1) begin
      errors++; $display("[TB] FAIL fml_runs: got add=%0d mul=%0d div=%0d stable=%b expected 0/26/0/1", na, nm, nd, st);
    end
  endtask

  task automatic test_fdv_then_flt();
    div_z = 32'h40400000;
    add_z = 32'h40400000;
    run_op(3'b101, 32'h40C00000, 32'h40000000, 1'b1, 3'b010, 32'h00000003);
    checks++;
    if (dc !== 28 || z !== 32'h40400000 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL fdv_result: got cycle=%0d z=%h err=%b expected 28/40400000/0", dc, z, e);
    end
    checks++;
    if (nd !== 27 || na !== 0 || nm !== 0) begin
      errors++; $display("[TB] FAIL fdv_runs: got add=%0d mul=%0d div=%0d expected 0/0/27", na, nm, nd);
    end
    // FLT was held through DONE, so it must still be waiting in this IDLE cycle
    checks++;
    if (pr !== 1'b1 || pv !== 1'b0 || add_run !== 1'b0) begin
      errors++; $display("[TB] FAIL flt_held_in_done: got ready=%b valid=%b add_run=%b expected 1/0/0", pr, pv, add_run);
    end
    run_op(3'b010, 32'h00000003, req_y, 1'b0, 3'b0, 32'h0);
    checks++;
    if (w !== 0 || dc !== 5 || z !== 32'h40400000 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL flt_result: got wait=%0d cycle=%0d z=%h err=%b expected 0/5/40400000/0", w, dc, z, e);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      logic [2:0] op;
      op = (i == 0) ? 3'b110 : 3'b111;
      run_op(op, $urandom, $urandom, 1'b0, 3'b0, 32'h0);
      checks++;
      if (dc !== 1 || z !== 32'h0 || e !== 1'b1) begin
        errors++; $display("[TB] FAIL illegal_%b: got cycle=%0d z=%h err=%b expected 1/00000000/1", op, dc, z, e);
      end
      checks++;
      if (na + nm + nd !== 0 || pv !== 1'b0 || pr !== 1'b1) begin
        errors++; $display("[TB] FAIL illegal_runs_%b: got runs=%0d next_valid=%b ready=%b expected 0/0/1", op, na + nm + nd, pv, pr);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_valid;
    saw_valid = 1'b0;
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; req_op = 3'b100; req_x = 32'h3FC00000; req_y = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (mul_run !== 1'b1) begin errors++; $display("[TB] FAIL midrst_running: got mul_run=%b expected 1", mul_run); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({add_run, mul_run, div_run} !== 3'b000) begin
      errors++; $display("[TB] FAIL midrst_async_drop: got runs=%b expected 000", {add_run, mul_run, div_run});
    end
    repeat (2) begin
      @(negedge clk);
      saw_valid |= (res_valid === 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 1", req_ready); end
    repeat (3) begin
      saw_valid |= (res_valid === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (saw_valid) begin errors++; $display("[TB] FAIL midrst_no_valid: got res_valid pulse expected none"); end
    add_z = 32'h00000003;
    run_op(3'b001, 32'h40400000, 32'h0, 1'b0, 3'b0, 32'h0);
    checks++;
    if (dc !== 5 || z !== 32'h00000003 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_flr: got cycle=%0d z=%h err=%b expected 5/00000003/0", dc, z, e);
    end
  endtask

`ifdef FPU_TMO_EN
  task automatic test_timeout();
    mul_z = 32'hDEADBEEF;
    mul_force = 1'b1;
    run_op(3'b100, 32'h3FC00000, 32'h40000000, 1'b0, 3'b0, 32'h0);
    mul_force = 1'b0;
    checks++;
    if (dc !== 64 || nm !== 63) begin
      errors++; $display("[TB] FAIL tmo_latency: got cycle=%0d mul_runs=%0d expected 64/63", dc, nm);
    end
    checks++;
    if (z !== 32'h0 || e !== 1'b1) begin
      errors++; $display("[TB] FAIL tmo_result: got z=%h err=%b expected 00000000/1", z, e);
    end
  endtask
`else
  task automatic test_no_timeout();
    mul_lat = 70;
    mul_z = 32'h12345678;
    run_op(3'b100, $urandom, $urandom, 1'b0, 3'b0, 32'h0);
    checks++;
    if (dc !== 71 || nm !== 70 || z !== 32'h12345678 || e !== 1'b0) begin
      errors++; $display("[TB] FAIL long_stall: got cycle=%0d runs=%0d z=%h err=%b expected 71/70/12345678/0", dc, nm, z, e);
    end
    mul_lat = 26;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] x, y, ez;
      int ec, ea, em, ed;
      add_lat = $urandom_range(1, 8);
      mul_lat = $urandom_range(1, 8);
      div_lat = $urandom_range(1, 8);
      add_z = $urandom; mul_z = $urandom; div_z = $urandom;
      op = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ec = model_cycles(op);
      ez = model_z(op);
      ea = (op[2] == 1'b0) ? add_lat : 0;
      em = (op == 3'b100) ? mul_lat : 0;
      ed = (op == 3'b101) ? div_lat : 0;
      run_op(op, x, y, 1'b0, 3'b0, 32'h0);
      checks++;
      if (dc !== ec) begin errors++; $display("[TB] FAIL rnd%0d_latency op=%b: got %0d expected %0d", i, op, dc, ec); end
      checks++;
      if (z !== ez || e !== (op[2:1] == 2'b11)) begin
        errors++; $display("[TB] FAIL rnd%0d_result op=%b: got z=%h err=%b expected z=%h err=%b", i, op, z, e, ez, op[2:1] == 2'b11);
      end
      checks++;
      if (na !== ea || nm !== em || nd !== ed) begin
        errors++; $display("[TB] FAIL rnd%0d_runs op=%b: got %0d/%0d/%0d expected %0d/%0d/%0d", i, op, na, nm, nd, ea, em, ed);
      end
      checks++;
      if (st !== 1'b1 || pv !== 1'b0 || pr !== 1'b1 || pz !== ez) begin
        errors++; $display("[TB] FAIL rnd%0d_after op=%b: got stable=%b valid=%b ready=%b z=%h expected 1/0/1/%h", i, op, st, pv, pr, pz, ez);
      end
    end
    add_lat = 4; mul_lat = 26; div_lat = 27;
  endtask

  initial begin
    test_reset();
    test_fad();
    test_fml();
    test_fdv_then_flt();
    test_illegal();
    test_reset_mid_run();
`ifdef FPU_TMO_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
